// File: rtl/adder_rr_scheduler.sv
// Round-robin front end for one shared external ripple-carry adder.
// It grants one requester, registers its operands onto the adder, then returns the sum with the requester ID.
module adder_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int SIZE    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*SIZE-1:0] req_a,
   input  logic [NUM_REQ*SIZE-1:0] req_b,
   input  logic [NUM_REQ-1:0]      req_cin,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [SIZE-1:0]         add_a,
   output logic [SIZE-1:0]         add_b,
   output logic                    add_cin,
   input  logic [SIZE-1:0]         add_sum,
   input  logic                    add_cout,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [SIZE-1:0]         rsp_sum,
   output logic                    rsp_cout,
   output logic                    busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADD  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   logic [1:0]      state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [SIZE-1:0] addA_q, addB_q, rspSum_q;
   logic            addCin_q, rspCout_q;
   logic [ID_W-1:0] rspId_q;

   logic [SIZE-1:0] reqA [NUM_REQ];
   logic [SIZE-1:0] reqB [NUM_REQ];

   logic            grantValid;
   logic [ID_W-1:0] grantIdx;
   logic            transfer;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gUnpack
      assign reqA[gi] = req_a[gi*SIZE +: SIZE];
      assign reqB[gi] = req_b[gi*SIZE +: SIZE];
   end

   // Search starts at ptr and wraps at NUM_REQ, so a non-power-of-two count never visits a phantom index.
   always_comb begin
      int idx;
      grantValid = 1'b0;
      grantIdx   = '0;
      idx        = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grantValid && req_valid[ID_W'(idx)]) begin
            grantValid = 1'b1;
            grantIdx   = ID_W'(idx);
         end
      end
   end

   assign transfer  = grantValid && (state_q == IDLE);
   assign req_ready = (transfer && !rst) ? (NUM_REQ'(1) << grantIdx) : '0;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (transfer) begin
               state_d = ADD;
               ptr_d   = (grantIdx == LAST_ID) ? '0 : grantIdx + ID_W'(1);
            end
         end
         ADD:     state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         addA_q    <= '0;
         addB_q    <= '0;
         addCin_q  <= 1'b0;
         rspId_q   <= '0;
         rspSum_q  <= '0;
         rspCout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (transfer) begin
            addA_q   <= reqA[grantIdx];
            addB_q   <= reqB[grantIdx];
            addCin_q <= req_cin[grantIdx];
            rspId_q  <= grantIdx;
         end
         // The adder had the whole ADD cycle to settle on the registered operands.
         if (state_q == ADD) begin
            rspSum_q  <= add_sum;
            rspCout_q <= add_cout;
         end
      end
   end

   assign add_a     = addA_q;
   assign add_b     = addB_q;
   assign add_cin   = addCin_q;
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = rspId_q;
   assign rsp_sum   = rspSum_q;
   assign rsp_cout  = rspCout_q;
   assign busy      = (state_q != IDLE);

endmodule
